// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver constants and types.
// Frame: start(0), 8 data bits LSB-first, odd parity, stop(1).
package ps2_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START_BIT  = 1'b0;
  localparam logic PS2_STOP_BIT   = 1'b1;
  localparam int   PS2_CODE_W     = 8;

  typedef logic [PS2_CODE_W-1:0] scan_code_t;

  // Prefix codes recognised by the downstream scan-code decoders.
  localparam scan_code_t PS2_BREAK_CODE = 8'hF0;
  localparam scan_code_t PS2_EXT_CODE   = 8'hE0;

  // Outcome of the stop-bit edge of a frame.
  typedef enum logic [1:0] {
    FRM_NONE,
    FRM_GOOD,
    FRM_BAD
  } frame_status_t;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous show-ahead FIFO: rd_data always shows the head entry.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = PS2_CODE_W
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally through the extra MSB.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit deframer and scan-code FIFO.
// Optional feature macro PS2_TIMEOUT_EN: an idle counter aborts a partial
// frame after TIMEOUT_CYC cycles without a ps2_clk falling edge.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  logic [2:0]                r_clk_hist;
  logic [1:0]                r_data_sync;
  logic [3:0]                r_cnt;
  logic [PS2_FRAME_BITS-2:0] r_buf;
  logic                      r_overflow;
  logic                      r_frame_err;

  logic          w_fall;
  logic          w_data_s;
  logic          w_last;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  logic          w_timeout;
  frame_status_t w_status;

  assign w_fall   = r_clk_hist[2] & ~r_clk_hist[1];
  assign w_data_s = r_data_sync[1];
  assign w_last   = (r_cnt == 4'(PS2_FRAME_BITS - 1));
  assign w_pop    = !nextdata_n;

  // Pin synchronisers; idle bus level is high.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_clk_hist  <= 3'b111;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_hist  <= {r_clk_hist[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
    end
  end

  // Judge the frame on the stop-bit edge: start low, stop high, odd parity.
  always_comb begin
    w_status = FRM_NONE;
    if (w_fall && w_last) begin
      if (r_buf[0] == PS2_START_BIT && w_data_s == PS2_STOP_BIT &&
          (^r_buf[PS2_FRAME_BITS-2:1]) == 1'b1)
        w_status = FRM_GOOD;
      else
        w_status = FRM_BAD;
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC) + 1;
  logic [IDLE_W-1:0] r_idle;

  // Idle counter: runs only inside a frame, restarted by every falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)                      r_idle <= '0;
    else if (w_fall || r_cnt == '0) r_idle <= '0;
    else                            r_idle <= r_idle + 1'b1;
  end

  assign w_timeout = (r_cnt != '0) && !w_fall &&
                     (r_idle == IDLE_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Bit collector: shift bits in on each fall, restart after the stop bit.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (w_fall) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_buf[r_cnt] <= w_data_s;
        r_cnt        <= r_cnt + 1'b1;
      end
    end else if (w_timeout) begin
      r_cnt <= '0;
    end
  end

  assign w_push = (w_status == FRM_GOOD);
  // When full the FIFO is non-empty, so a low nextdata_n is a real pop.
  assign w_drop = w_push && w_full && !w_pop;

  // Sticky flags: cleared by any pop request, but a new error wins.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)     r_overflow <= 1'b1;
      else if (w_pop) r_overflow <= 1'b0;
      if (w_status == FRM_BAD || w_timeout) r_frame_err <= 1'b1;
      else if (w_pop)                       r_frame_err <= 1'b0;
    end
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_CODE_W)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .push    (w_push),
    .wr_data (r_buf[PS2_CODE_W:1]),
    .pop     (w_pop),
    .rd_data (data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign ready     = !w_empty;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx. The reference model collects the
// received bit stream into 11-bit groups and keeps the FIFO as a byte queue.
// The PS/2 clock is run much faster than a real keyboard to keep runs short.
module tb_ps2_keyboard_rx;

  localparam int HALF  = 20;   // clk cycles per ps2_clk half period
  localparam int TMO   = 300;  // TIMEOUT_CYC used for the DUT
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] m_q[$];
  logic       m_bits[$];
  logic       m_over = 1'b0;
  logic       m_err  = 1'b0;

  always #10 clk = ~clk;

  ps2_keyboard_rx #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_bits.delete();
    m_over = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_pop();
    if (m_q.size() != 0) void'(m_q.pop_front());
    m_over = 1'b0;
    m_err  = 1'b0;
  endtask

  // One received bit; every 11 bits form a frame that is judged and queued.
  task automatic model_bit(input logic b, input bit popnow);
    logic [7:0] code;
    int ones;
    bit good;
    if (popnow) model_pop();
    m_bits.push_back(b);
    if (m_bits.size() == 11) begin
      ones = 0;
      for (int i = 1; i <= 9; i++) ones += int'(m_bits[i]);
      for (int i = 0; i < 8; i++) code[i] = m_bits[i+1];
      good = (m_bits[0] == 1'b0) && (m_bits[10] == 1'b1) && (ones % 2 == 1);
      if (good) begin
        if (m_q.size() < DEPTH) m_q.push_back(code);
        else m_over = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_bits.delete();
    end
  endtask

  // A long idle gap abandons a partial frame only when the timeout is built.
  task automatic model_idle();
`ifdef PS2_TIMEOUT_EN
    if (m_bits.size() != 0) begin
      m_bits.delete();
      m_err = 1'b1;
    end
`endif
  endtask

  // mode 0: plain bit; 1: pop in the cycle the edge is processed; 2: measure ready latency
  task automatic drive_bit(input logic b, input int mode, output int lat);
    lat = -1;
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (mode == 1) begin
      repeat (2) @(posedge clk);
      #1 nextdata_n = 1'b0;
      @(posedge clk);
      #1 nextdata_n = 1'b1;
      repeat (HALF - 3) @(posedge clk);
    end else if (mode == 2) begin
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk);
        #1;
        if (ready === 1'b1 && lat < 0) lat = k;
      end
      repeat (HALF - 6) @(posedge clk);
    end else begin
      repeat (HALF) @(posedge clk);
    end
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] code, input bit badpar, input int nbits,
                           input int mode, output int lat);
    logic [10:0] f;
    int l;
    f[0]   = 1'b0;
    f[8:1] = code;
    f[9]   = (~^code) ^ badpar;
    f[10]  = 1'b1;
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      drive_bit(f[i], (i == 10) ? mode : 0, l);
      model_bit(f[i], (i == 10) && (mode == 1));
      if (i == 10) lat = l;
    end
  endtask

  task automatic send_frame(input logic [7:0] code, input bit badpar, input int mode,
                            output int lat);
    send_bits(code, badpar, 11, mode, lat);
    settle(2);
  endtask

  task automatic pop_once();
    @(posedge clk);
    #1 nextdata_n = 1'b0;
    @(posedge clk);
    #1 nextdata_n = 1'b1;
    model_pop();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ready"}, 8'(ready), 8'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, "_data"}, data, m_q[0]);
    chk({tag, "_overflow"}, 8'(overflow), 8'(m_over));
    chk({tag, "_frame_err"}, 8'(frame_err), 8'(m_err));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (m_q.size() == 0) break;
      pop_once();
      settle(1);
      check_state(tag);
    end
    chk({tag, "_empty"}, 8'(ready), 8'h00);
  endtask

  initial begin
    int lat;
    logic [7:0] code;
    bit bad;

    // Reset state
    clrn = 1'b0;
    settle(3);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", 8'(ready), 8'h00);
    chk("rst_overflow", 8'(overflow), 8'h00);
    chk("rst_frame_err", 8'(frame_err), 8'h00);
    clrn = 1'b1;
    settle(3);

    // 1: single frame, latency, pop
    send_frame(8'h1C, 1'b0, 2, lat);
    chk("t1_latency_le4", 8'(lat >= 1 && lat <= 4), 8'h01);
    chk("t1_data", data, 8'h1C);
    check_state("t1");
    pop_once();
    settle(1);
    chk("t1_ready_after_pop", 8'(ready), 8'h00);
    check_state("t1_pop");

    // 2: overflow with nine frames, then drain in order
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0, lat);
    chk("t2_overflow", 8'(overflow), 8'h01);
    chk("t2_head", data, 8'h01);
    check_state("t2_full");
    drain("t2");

    // 3: parity error, then a good frame
    send_frame(8'h1C, 1'b1, 0, lat);
    chk("t3_err", 8'(frame_err), 8'h01);
    chk("t3_ready", 8'(ready), 8'h00);
    check_state("t3_bad");
    send_frame(8'h5A, 1'b0, 0, lat);
    chk("t3_data", data, 8'h5A);
    check_state("t3_good");
    drain("t3");

    // 4: reset mid-frame, then a clean frame
    send_bits(8'h77, 1'b0, 5, 0, lat);
    clrn = 1'b0;
    model_reset();
    settle(2);
    chk("t4_rst_ready", 8'(ready), 8'h00);
    chk("t4_rst_data", data, 8'h00);
    clrn = 1'b1;
    settle(2);
    send_frame(8'hF0, 1'b0, 0, lat);
    chk("t4_data", data, 8'hF0);
    chk("t4_err", 8'(frame_err), 8'h00);
    check_state("t4");
    pop_once();
    settle(1);
    chk("t4_single_entry", 8'(ready), 8'h00);
    check_state("t4_pop");

    // 5: push and pop in the same cycle while full
    for (int i = 0; i < DEPTH; i++) send_frame(8'hA0 + 8'(i), 1'b0, 0, lat);
    check_state("t5_full");
    send_frame(8'h33, 1'b0, 1, lat);
    chk("t5_overflow", 8'(overflow), 8'h00);
    chk("t5_head", data, 8'hA1);
    check_state("t5");
    drain("t5");

    // Randomised frames with occasional parity errors and pops
    for (int r = 0; r < 14; r++) begin
      code = 8'($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      send_frame(code, bad, 0, lat);
      check_state("rnd_frame");
      if ($urandom_range(0, 2) == 0) begin
        pop_once();
        settle(1);
        check_state("rnd_pop");
      end
    end
    drain("rnd");

    // 6: abandoned partial frame, long idle, then 0x5A
    send_bits(8'h3C, 1'b0, 4, 0, lat);
    settle(2 * TMO);
    model_idle();
    check_state("t6_idle");
    send_frame(8'h5A, 1'b0, 0, lat);
    check_state("t6");
`ifdef PS2_TIMEOUT_EN
    chk("t6_data", data, 8'h5A);
    chk("t6_err", 8'(frame_err), 8'h01);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
